// File: rtl/pet_pkg.sv
// Shared definitions for the pet mood display: mood codes, level limits,
// display indices and the input clamp helper.
package pet_pkg;

  typedef enum logic [2:0] {
    MOOD_HAPPY   = 3'd0,
    MOOD_NEUTRAL = 3'd1,
    MOOD_HUNGRY  = 3'd2,
    MOOD_TIRED   = 3'd3,
    MOOD_BORED   = 3'd4,
    MOOD_WEAK    = 3'd5,
    MOOD_DEAD    = 3'd6
  } mood_t;

  localparam logic [2:0] LVL_MIN   = 3'd1;
  localparam logic [2:0] LVL_MAX   = 3'd5;
  // Every need must be at least this high for the pet to be happy.
  localparam logic [2:0] LVL_HAPPY = 3'd4;

  localparam logic [1:0] IDX_NH = 2'd0;
  localparam logic [1:0] IDX_NS = 2'd1;
  localparam logic [1:0] IDX_NF = 2'd2;
  localparam logic [1:0] IDX_NE = 2'd3;

  // Out-of-range levels are pulled into LVL_MIN..LVL_MAX.
  function automatic logic [2:0] clamp_lvl(input logic [2:0] v);
    if (v < LVL_MIN)      return LVL_MIN;
    else if (v > LVL_MAX) return LVL_MAX;
    else                  return v;
  endfunction

endpackage

// File: rtl/pet_mood_display_tick_hold_counter.sv
// Tick-enabled counter with synchronous clear (priority over the enable)
// and a flag raised on the last count before the limit. WRAP=1 rolls over
// to 0 after LIMIT-1; WRAP=0 saturates at LIMIT.
module tick_hold_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] r_cnt;

  // Count enabled ticks; a clear in the same cycle wins over the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (WRAP && (r_cnt == LAST))       r_cnt <= '0;
      else if (!WRAP && (r_cnt == TOP))  r_cnt <= r_cnt;
      else                               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/pet_mood_display.sv
// Turns the four need levels into a debounced mood code, a blinking alarm
// and a scrolling single-level readout, and latches DEAD after sustained
// neglect. Everything advances on the one-cycle tick enable.
module pet_mood_display
  import pet_pkg::*;
#(
  parameter int HOLD_TICKS   = 3,
  parameter int DEATH_TICKS  = 120,
  parameter int SCROLL_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] NH,
  input  logic [2:0] NS,
  input  logic [2:0] NF,
  input  logic [2:0] NE,
  output logic [2:0] mood,
  output logic       alarm,
  output logic       dead,
  output logic [1:0] disp_sel,
  output logic [2:0] disp_val
);

  logic [2:0] w_nh, w_ns, w_nf, w_ne;
  logic       w_any_low;
  mood_t      w_cand;
  logic       w_cand_chg;
  logic       w_hold_tc, w_starve_tc, w_scroll_tc;
  logic       w_adopt, w_dead_set, w_scroll_step;
  logic       w_mood_alarm;
  logic [2:0] w_sel_lvl;

  mood_t      r_mood;
  mood_t      r_prev_cand;
  logic       r_dead;
  logic       r_blink;
  logic [1:0] r_disp_sel;
  logic [2:0] r_disp_val;

  assign w_nh = clamp_lvl(NH);
  assign w_ns = clamp_lvl(NS);
  assign w_nf = clamp_lvl(NF);
  assign w_ne = clamp_lvl(NE);

  assign w_any_low = (w_nh == LVL_MIN) || (w_ns == LVL_MIN) ||
                     (w_nf == LVL_MIN) || (w_ne == LVL_MIN);

  // Candidate mood by strict priority: hunger, sleep, fun, energy, then happy.
  always_comb begin
    w_cand = MOOD_NEUTRAL;
    if (w_nh == LVL_MIN)      w_cand = MOOD_HUNGRY;
    else if (w_ns == LVL_MIN) w_cand = MOOD_TIRED;
    else if (w_nf == LVL_MIN) w_cand = MOOD_BORED;
    else if (w_ne == LVL_MIN) w_cand = MOOD_WEAK;
    else if ((w_nh >= LVL_HAPPY) && (w_ns >= LVL_HAPPY) &&
             (w_nf >= LVL_HAPPY) && (w_ne >= LVL_HAPPY))
      w_cand = MOOD_HAPPY;
  end

  assign w_cand_chg = (w_cand != r_prev_cand);

  tick_hold_counter #(.W(4), .LIMIT(HOLD_TICKS), .WRAP(1'b1)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .i_en  (tick & ~r_dead),
    .i_clr (w_cand_chg & ~r_dead),
    .o_tc  (w_hold_tc)
  );

  tick_hold_counter #(.W(8), .LIMIT(DEATH_TICKS), .WRAP(1'b0)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_en  (tick & w_any_low & ~r_dead),
    .i_clr (~w_any_low),
    .o_tc  (w_starve_tc)
  );

  tick_hold_counter #(.W(4), .LIMIT(SCROLL_TICKS), .WRAP(1'b1)) u_scroll (
    .clk   (clk),
    .rst   (rst),
    .i_en  (tick & ~r_dead),
    .i_clr (1'b0),
    .o_tc  (w_scroll_tc)
  );

  assign w_adopt       = tick & ~r_dead & ~w_cand_chg & w_hold_tc;
  assign w_dead_set    = tick & ~r_dead & w_any_low & w_starve_tc;
  assign w_scroll_step = tick & ~r_dead & w_scroll_tc;

  // Debounced mood, candidate history and the absorbing DEAD latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mood      <= MOOD_NEUTRAL;
      r_prev_cand <= MOOD_HAPPY;
      r_dead      <= 1'b0;
    end else if (!r_dead) begin
      r_prev_cand <= w_cand;
      if (w_dead_set) begin
        r_dead <= 1'b1;
        r_mood <= MOOD_DEAD;
      end else if (w_adopt) begin
        r_mood <= w_cand;
      end
    end
  end

  assign w_mood_alarm = (r_mood == MOOD_HUNGRY) || (r_mood == MOOD_TIRED) ||
                        (r_mood == MOOD_BORED)  || (r_mood == MOOD_WEAK);

  // Blink phase; parked low in calm moods so a new alarm opens with the off phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink <= 1'b0;
    end else if (!r_dead) begin
      if (!w_mood_alarm) r_blink <= 1'b0;
      else if (tick)     r_blink <= ~r_blink;
    end
  end

  always_comb begin
    w_sel_lvl = w_nh;
    case (r_disp_sel)
      IDX_NS:  w_sel_lvl = w_ns;
      IDX_NF:  w_sel_lvl = w_nf;
      IDX_NE:  w_sel_lvl = w_ne;
      default: w_sel_lvl = w_nh;
    endcase
  end

  // Scrolled readout: selector steps on scroll wrap, value follows one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_sel <= IDX_NH;
      r_disp_val <= 3'd0;
    end else begin
      if (w_scroll_step) r_disp_sel <= r_disp_sel + 2'd1;
      r_disp_val <= r_dead ? 3'd0 : w_sel_lvl;
    end
  end

  assign mood     = r_mood;
  assign dead     = r_dead;
  assign alarm    = r_dead | (r_blink & w_mood_alarm);
  assign disp_sel = r_disp_sel;
  assign disp_val = r_disp_val;

endmodule

// File: tb/tb_pet_mood_display.sv
// Scoreboard bench for pet_mood_display: the driver queues expected output
// snapshots, the monitor pops and compares them on the falling clock edge.
module tb_pet_mood_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] NH = 3'd3, NS = 3'd3, NF = 3'd3, NE = 3'd3;
  logic [2:0] mood;
  logic       alarm, dead;
  logic [1:0] disp_sel;
  logic [2:0] disp_val;

  int checks = 0;
  int errors = 0;
  logic chk_req = 1'b0;

  localparam logic [4:0] M_MOOD  = 5'b00001;
  localparam logic [4:0] M_ALARM = 5'b00010;
  localparam logic [4:0] M_DEAD  = 5'b00100;
  localparam logic [4:0] M_SEL   = 5'b01000;
  localparam logic [4:0] M_VAL   = 5'b10000;
  localparam logic [4:0] M_ALL   = 5'b11111;

  typedef struct {
    string      name;
    int         mood;
    int         alarm;
    int         dead;
    int         sel;
    int         val;
    logic [4:0] mask;
  } exp_t;

  exp_t q[$];

  pet_mood_display #(
    .HOLD_TICKS  (3),
    .DEATH_TICKS (10),
    .SCROLL_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .NH       (NH),
    .NS       (NS),
    .NF       (NF),
    .NE       (NE),
    .mood     (mood),
    .alarm    (alarm),
    .dead     (dead),
    .disp_sel (disp_sel),
    .disp_val (disp_val)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per requested sample.
  always @(negedge clk) begin
    if (chk_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: sample requested with empty queue, expected an entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.mask[0]) cmp(e.name, "mood",     int'(mood),     e.mood);
        if (e.mask[1]) cmp(e.name, "alarm",    int'(alarm),    e.alarm);
        if (e.mask[2]) cmp(e.name, "dead",     int'(dead),     e.dead);
        if (e.mask[3]) cmp(e.name, "disp_sel", int'(disp_sel), e.sel);
        if (e.mask[4]) cmp(e.name, "disp_val", int'(disp_val), e.val);
      end
    end
  end

  task automatic chk(input string nm, input int m, input int a, input int d,
                     input int s, input int v, input logic [4:0] mk);
    exp_t e;
    e.name = nm; e.mood = m; e.alarm = a; e.dead = d; e.sel = s; e.val = v; e.mask = mk;
    q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic set_lvls(input logic [2:0] h, input logic [2:0] s,
                          input logic [2:0] f, input logic [2:0] e);
    NH = h; NS = s; NF = f; NE = e;
  endtask

  // Tick followed by an idle clock.
  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
  endtask

  // Tick with no idle clock afterwards.
  task automatic tick_now();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [2:0] h, input logic [2:0] s,
                          input logic [2:0] f, input logic [2:0] e);
    rst = 1'b1;
    set_lvls(h, s, f, e);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int sel_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int val_seq[9] = '{1, 1, 5, 5, 2, 2, 4, 4, 1};

  initial begin
    // Reset state and first registered readout
    @(posedge clk); #1;
    chk("reset", 1, 0, 0, 0, 0, M_ALL);
    rst = 1'b0;
    idle();
    chk("after_reset", 1, 0, 0, 0, 3, M_ALL);

    // All levels 5: HAPPY only on the third tick
    set_lvls(3'd5, 3'd5, 3'd5, 3'd5);
    idle();
    do_tick();
    do_tick();
    chk("happy_tick2", 1, 0, 0, 0, 0, M_MOOD);
    do_tick();
    chk("happy_tick3", 0, 0, 0, 0, 0, M_MOOD | M_ALARM);

    // NH and NS low together: HUNGRY wins, alarm starts in the off phase
    do_reset(3'd1, 3'd1, 3'd3, 3'd3);
    do_tick();
    do_tick();
    chk("hungry_tick2", 1, 0, 0, 0, 0, M_MOOD | M_ALARM);
    do_tick();
    chk("hungry_tick3", 2, 0, 0, 0, 0, M_MOOD | M_ALARM | M_DEAD);
    do_tick();
    chk("blink_1", 2, 1, 0, 0, 0, M_MOOD | M_ALARM);
    do_tick();
    chk("blink_2", 2, 0, 0, 0, 0, M_ALARM);
    do_tick();
    chk("blink_3", 2, 1, 0, 0, 0, M_ALARM);

    // NF toggling with the change landing on a tick keeps mood NEUTRAL
    do_reset(3'd3, 3'd3, 3'd3, 3'd3);
    NF = 3'd1;
    do_tick();
    do_tick();
    do_tick();
    chk("nf_toggle_1", 1, 0, 0, 0, 0, M_MOOD | M_ALARM);
    NF = 3'd3;
    do_tick();
    do_tick();
    do_tick();
    chk("nf_toggle_2", 1, 0, 0, 0, 0, M_MOOD);
    NF = 3'd1;
    do_tick();
    do_tick();
    do_tick();
    chk("nf_toggle_3", 1, 0, 0, 0, 0, M_MOOD);

    // Sustained NE=1: dead latches on the tenth tick and is absorbing
    do_reset(3'd3, 3'd3, 3'd3, 3'd1);
    for (int i = 0; i < 9; i++) do_tick();
    chk("starve_9", 5, 0, 0, 0, 0, M_MOOD | M_DEAD);
    do_tick();
    chk("starve_10", 6, 1, 1, 1, 0, M_ALL);
    set_lvls(3'd5, 3'd5, 3'd5, 3'd5);
    for (int i = 0; i < 4; i++) do_tick();
    chk("dead_hold", 6, 1, 1, 1, 0, M_ALL);
    #2;
    rst = 1'b1;
    chk("mid_reset", 1, 0, 0, 0, 0, M_ALL);
    rst = 1'b0;
    idle();
    chk("post_reset", 1, 0, 0, 0, 5, M_ALL);

    // Scrolled readout with clamped inputs and one-clk value lag
    do_reset(3'd0, 3'd7, 3'd2, 3'd4);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scroll_%0d", k), 0, 0, 0, sel_seq[k], val_seq[k], M_SEL | M_VAL);
      tick_now();
      if (k % 2 == 1)
        chk($sformatf("scroll_lag_%0d", k), 0, 0, 0, sel_seq[k+1], val_seq[k], M_SEL | M_VAL);
    end
    chk("scroll_wrap", 0, 0, 0, sel_seq[8], val_seq[8], M_SEL | M_VAL | M_DEAD);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
